// File: rtl/receiver_spi_slave_pkg.sv
// rtl/receiver_spi_slave_pkg.sv - shared types, constants and mode helpers for the SPI receiver
// Purpose : FSM state encoding, SPI mode constants ({CKP,CPH}) and the default word length.
//           The transmitter side of the link decodes modes with the same helpers.
// Ports   : none (package)
package receiver_spi_slave_pkg;

   localparam int DEFAULT_DATA_W = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Mode constants, encoded as {CKP, CPH}
   localparam logic [1:0] MODE_00 = 2'b00;
   localparam logic [1:0] MODE_01 = 2'b01;
   localparam logic [1:0] MODE_10 = 2'b10;
   localparam logic [1:0] MODE_11 = 2'b11;

   // CPH=1 samples on the falling SCK edge
   function automatic logic samples_on_fall(input logic [1:0] mode);
      return (mode == MODE_01) || (mode == MODE_11);
   endfunction

   // CKP=0 means SCK idles high
   function automatic logic sck_idle_level(input logic [1:0] mode);
      return (mode == MODE_00) || (mode == MODE_01);
   endfunction

endpackage

// File: rtl/receiver_spi_slave_if.sv
// rtl/receiver_spi_slave_if.sv - SPI link plus receive-side consumer handshake bundle
// Purpose : groups the SPI pins (CKP, CPH, SCK, CS, MOSI, MISO) and the local word interface
//           (tx_data, rx_data, rx_valid, rx_ack, busy).
// Modports: slave  - the receiver_spi_slave side
//           master - the SPI master / local consumer side
// Config  : SPI_RX_OVERRUN_EN adds the sticky rx_overrun flag.
interface receiver_spi_slave_if #(
   parameter int DATA_W = 8
);
   logic              CKP;
   logic              CPH;
   logic              SCK;
   logic              CS;
   logic              MOSI;
   logic              MISO;
   logic [DATA_W-1:0] tx_data;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ack;
   logic              busy;
`ifdef SPI_RX_OVERRUN_EN
   logic              rx_overrun;

   modport slave (
      input  CKP, CPH, SCK, CS, MOSI, tx_data, rx_ack,
      output MISO, rx_data, rx_valid, busy, rx_overrun
   );
   modport master (
      output CKP, CPH, SCK, CS, MOSI, tx_data, rx_ack,
      input  MISO, rx_data, rx_valid, busy, rx_overrun
   );
`else
   modport slave (
      input  CKP, CPH, SCK, CS, MOSI, tx_data, rx_ack,
      output MISO, rx_data, rx_valid, busy
   );
   modport master (
      output CKP, CPH, SCK, CS, MOSI, tx_data, rx_ack,
      input  MISO, rx_data, rx_valid, busy
   );
`endif
endinterface

// File: rtl/receiver_spi_slave_sync_edge.sv
// rtl/receiver_spi_slave_sync_edge.sv - N-stage synchronizer with registered level and edge pulses
// Purpose : brings an asynchronous input into the clk domain and reports its edges.
// Ports   : clk, rst (async active-low)
//           d         - asynchronous input
//           force_en  - load the edge-detect history with force_val and suppress edges this cycle
//           force_val - history value used with force_en
//           level     - synchronized level, aligned with the pulses
//           rise/fall - one-cycle edge pulses
module receiver_spi_slave_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   input  logic force_en,
   input  logic force_val,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
      prev_d = sync_q[STAGES-1];
      rise_d = sync_q[STAGES-1] & ~prev_q;
      fall_d = ~sync_q[STAGES-1] & prev_q;
      if (force_en) begin
         prev_d = force_val;
         rise_d = 1'b0;
         fall_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   // prev_q is the synchronized level one cycle after the last stage, matching the pulses
   assign level = prev_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/receiver_spi_slave.sv
// rtl/receiver_spi_slave.sv - SPI slave receiver: LSB-first words in, tx_data out on MISO
// Purpose : oversamples SCK/CS/MOSI, shifts in one DATA_W word per CS-low word slot, returns
//           tx_data on MISO, and hands received words to the consumer via rx_valid/rx_ack.
// Ports   : clk, rst (async active-low), bus (receiver_spi_slave_if.slave)
// Config  : SPI_RX_OVERRUN_EN adds bus.rx_overrun (sticky, cleared by rx_ack).
module receiver_spi_slave
   import receiver_spi_slave_pkg::*;
#(
   parameter int DATA_W      = DEFAULT_DATA_W,
   parameter int SYNC_STAGES = 2
) (
   input logic                 clk,
   input logic                 rst,
   receiver_spi_slave_if.slave bus
);
   localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   logic sck_level, sck_rise, sck_fall;
   logic cs_level, cs_rise, cs_fall;
   logic mosi_level, mosi_rise, mosi_fall;
   logic sck_force, sample_edge, shift_edge;
   logic unused_sync;

   state_t            state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   // The last bit of a word goes straight into rx_data, so only DATA_W-1 bits are stored
   logic [DATA_W-2:0] rx_shr_q, rx_shr_d;
   logic [DATA_W-1:0] rx_word;
   logic [DATA_W-1:0] tx_shr_q, tx_shr_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              miso_q, miso_d;
   logic              pend_q, pend_d;
`ifdef SPI_RX_OVERRUN_EN
   logic              overrun_q, overrun_d;
`endif

   // Forcing the SCK history to the idle level at CS fall hides any SCK movement seen while idle
   assign sck_force = (state_q == ST_IDLE) && cs_fall;

   receiver_spi_slave_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
      .clk(clk), .rst(rst), .d(bus.SCK),
      .force_en(sck_force), .force_val(sck_idle_level({bus.CKP, bus.CPH})),
      .level(sck_level), .rise(sck_rise), .fall(sck_fall)
   );
   receiver_spi_slave_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
      .clk(clk), .rst(rst), .d(bus.CS), .force_en(1'b0), .force_val(1'b0),
      .level(cs_level), .rise(cs_rise), .fall(cs_fall)
   );
   receiver_spi_slave_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi_sync (
      .clk(clk), .rst(rst), .d(bus.MOSI), .force_en(1'b0), .force_val(1'b0),
      .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
   );

   assign unused_sync = ^{sck_level, cs_level, mosi_rise, mosi_fall};

   assign sample_edge = samples_on_fall(mode_q) ? sck_fall : sck_rise;
   assign shift_edge  = samples_on_fall(mode_q) ? sck_rise : sck_fall;

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      bit_cnt_d  = bit_cnt_q;
      rx_shr_d   = rx_shr_q;
      tx_shr_d   = tx_shr_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      miso_d     = miso_q;
      pend_d     = pend_q;
      rx_word    = {mosi_level, rx_shr_q};
`ifdef SPI_RX_OVERRUN_EN
      overrun_d  = overrun_q;
`endif
      if (bus.rx_ack) begin
         rx_valid_d = 1'b0;
`ifdef SPI_RX_OVERRUN_EN
         overrun_d  = 1'b0;
`endif
      end

      case (state_q)
         ST_IDLE: begin
            miso_d = 1'b0;
            if (cs_fall) begin
               state_d   = ST_SHIFT;
               mode_d    = {bus.CKP, bus.CPH};
               bit_cnt_d = '0;
               pend_d    = 1'b0;
               // Bit 0 is driven now; tx_shr always holds the bits still to be presented
               miso_d    = bus.tx_data[0];
               tx_shr_d  = bus.tx_data >> 1;
            end
         end
         ST_SHIFT: begin
            if (cs_rise) begin
               state_d = ST_IDLE;
               miso_d  = 1'b0;
            end else if (sample_edge) begin
               rx_shr_d = rx_word[DATA_W-1:1];
               pend_d   = 1'b1;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d  = '0;
                  rx_data_d  = rx_word;
                  rx_valid_d = 1'b1;
                  tx_shr_d   = bus.tx_data;
`ifdef SPI_RX_OVERRUN_EN
                  if (rx_valid_q && !bus.rx_ack) overrun_d = 1'b1;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else if (shift_edge && pend_q) begin
               // A shift edge before any sample (CPHA-style leading edge) must not advance MISO
               miso_d   = tx_shr_q[0];
               tx_shr_d = tx_shr_q >> 1;
               pend_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         mode_q     <= MODE_00;
         bit_cnt_q  <= '0;
         rx_shr_q   <= '0;
         tx_shr_q   <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         miso_q     <= 1'b0;
         pend_q     <= 1'b0;
`ifdef SPI_RX_OVERRUN_EN
         overrun_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_shr_q   <= rx_shr_d;
         tx_shr_q   <= tx_shr_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         miso_q     <= miso_d;
         pend_q     <= pend_d;
`ifdef SPI_RX_OVERRUN_EN
         overrun_q  <= overrun_d;
`endif
      end
   end

   assign bus.MISO     = miso_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.busy     = (state_q == ST_SHIFT);
`ifdef SPI_RX_OVERRUN_EN
   assign bus.rx_overrun = overrun_q;
`endif

endmodule

// File: tb/tb_receiver_spi_slave.sv
// tb/tb_receiver_spi_slave.sv - directed scoreboard bench for receiver_spi_slave
module tb_receiver_spi_slave;
   localparam int W = 8;
   localparam int H = 8;   // SCK half period in clk cycles

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   receiver_spi_slave_if #(.DATA_W(W)) bus ();
   receiver_spi_slave #(.DATA_W(W), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

   int tests = 0;
   int fails = 0;
   int rx_count = 0;
   int count0;
   logic auto_ack = 1'b0;
   logic busy_drop;
   logic [W-1:0] sb_q[$];
   logic [2*W-1:0] miso_bits;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic cs_fall(input logic ckp, input logic cph, input logic [W-1:0] txw);
      bus.CKP = ckp;
      bus.CPH = cph;
      bus.SCK = ~ckp;
      bus.tx_data = txw;
      wait_clk(H);
      bus.CS = 1'b0;
   endtask

   task automatic cs_rise();
      wait_clk(H);
      bus.CS = 1'b1;
      wait_clk(H);
   endtask

   // Master side: drives MOSI on shift edges, captures MISO just before each sample edge
   task automatic shift_bits(input logic ckp, input logic cph, input logic [2*W-1:0] mosi_w,
                             input int nbits);
      logic lead_smp;
      lead_smp = ckp ^ cph;
      miso_bits = '0;
      for (int i = 0; i < nbits; i++) begin
         if (lead_smp) bus.MOSI = mosi_w[i];
         wait_clk(H);
         if (!bus.busy) busy_drop = 1'b1;
         if (lead_smp) miso_bits[i] = bus.MISO;
         else bus.MOSI = mosi_w[i];
         bus.SCK = ckp;
         wait_clk(H);
         if (!lead_smp) miso_bits[i] = bus.MISO;
         bus.SCK = ~ckp;
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
      wait_clk(3);
      tests++;
      assert (sb_q.size() == 0) else begin
         fails++;
         $error("FAIL drain_timeout: observed %0d pending expected 0", sb_q.size());
      end
   endtask

   // Consumer: pops the scoreboard whenever a word is presented, then acknowledges it
   initial begin : ack_monitor
      logic [W-1:0] exp_word;
      bus.rx_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.rx_ack) begin
            bus.rx_ack = 1'b0;
         end else if (auto_ack && bus.rx_valid) begin
            tests++;
            assert (sb_q.size() != 0) else begin
               fails++;
               $error("FAIL sb_unexpected_word: observed %0h expected no word", bus.rx_data);
            end
            if (sb_q.size() != 0) begin
               exp_word = sb_q.pop_front();
               chk("sb_rx_data", bus.rx_data, exp_word);
            end
            rx_count++;
            bus.rx_ack = 1'b1;
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      logic [1:0] m;
      rst = 1'b0;
      bus.CS = 1'b1; bus.SCK = 1'b1; bus.MOSI = 1'b0;
      bus.CKP = 1'b0; bus.CPH = 1'b0; bus.tx_data = '0;
      wait_clk(3);
      chk("reset_miso", bus.MISO, 0);
      chk("reset_rx_data", bus.rx_data, 0);
      chk("reset_rx_valid", bus.rx_valid, 0);
      chk("reset_busy", bus.busy, 0);
`ifdef SPI_RX_OVERRUN_EN
      chk("reset_overrun", bus.rx_overrun, 0);
`endif
      rst = 1'b1;
      wait_clk(4);

      // Mode 00: A5 in, 3C out, latency from last sample edge
      cs_fall(1'b0, 1'b0, 8'h3C);
      shift_bits(1'b0, 1'b0, 16'h00A5, 8);
      repeat (3) @(posedge clk);
      #1 chk("latency_before", bus.rx_valid, 0);
      @(posedge clk);
      #1 chk("latency_at", bus.rx_valid, 1);
      chk("mode0_rx_data", bus.rx_data, 8'hA5);
      cs_rise();
      chk("mode0_master_rx", miso_bits[W-1:0], 8'h3C);
      chk("idle_miso", bus.MISO, 0);
      chk("idle_busy", bus.busy, 0);
      sb_q.push_back(8'hA5);
      auto_ack = 1'b1;
      wait_drain();
      chk("mode0_once", rx_count, 1);
      chk("mode0_valid_cleared", bus.rx_valid, 0);

      // Remaining modes, same words
      for (int k = 1; k < 4; k++) begin
         m = k[1:0];
         count0 = rx_count;
         sb_q.push_back(8'hA5);
         cs_fall(m[1], m[0], 8'h3C);
         shift_bits(m[1], m[0], 16'h00A5, 8);
         cs_rise();
         wait_drain();
         chk($sformatf("mode%0d_master_rx", k), miso_bits[W-1:0], 8'h3C);
         chk($sformatf("mode%0d_once", k), rx_count, count0 + 1);
      end

      // Two back-to-back words in one frame, acknowledged after each
      count0 = rx_count;
      busy_drop = 1'b0;
      sb_q.push_back(8'h01);
      sb_q.push_back(8'hFE);
      cs_fall(1'b0, 1'b0, 8'h3C);
      shift_bits(1'b0, 1'b0, 16'hFE01, 16);
      cs_rise();
      wait_drain();
      chk("b2b_count", rx_count, count0 + 2);
      chk("b2b_busy_held", busy_drop, 0);
      chk("b2b_master_rx", miso_bits, 16'h3C3C);

      // Aborted frame after 5 bits, then a full frame
      count0 = rx_count;
      cs_fall(1'b1, 1'b0, 8'h00);
      shift_bits(1'b1, 1'b0, 16'h00FF, 5);
      cs_rise();
      wait_clk(20);
      chk("abort_valid", bus.rx_valid, 0);
      chk("abort_rx_data", bus.rx_data, 8'hFE);
      chk("abort_count", rx_count, count0);
      sb_q.push_back(8'h5A);
      cs_fall(1'b1, 1'b0, 8'h00);
      shift_bits(1'b1, 1'b0, 16'h005A, 8);
      cs_rise();
      wait_drain();
      chk("after_abort_count", rx_count, count0 + 1);

      // Two words without acknowledge
      auto_ack = 1'b0;
      count0 = rx_count;
      cs_fall(1'b0, 1'b1, 8'h00);
      shift_bits(1'b0, 1'b1, 16'h55AA, 16);
      cs_rise();
      chk("overwrite_rx_data", bus.rx_data, 8'h55);
      chk("overwrite_valid", bus.rx_valid, 1);
`ifdef SPI_RX_OVERRUN_EN
      chk("overrun_set", bus.rx_overrun, 1);
`endif
      sb_q.push_back(8'h55);
      auto_ack = 1'b1;
      wait_drain();
      chk("overwrite_count", rx_count, count0 + 1);
`ifdef SPI_RX_OVERRUN_EN
      chk("overrun_cleared", bus.rx_overrun, 0);
`endif

      // Asynchronous reset in the middle of a frame
      count0 = rx_count;
      cs_fall(1'b0, 1'b0, 8'h81);
      shift_bits(1'b0, 1'b0, 16'h00FF, 3);
      #1 rst = 1'b0;
      #1;
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_rx_data", bus.rx_data, 0);
      chk("midrst_valid", bus.rx_valid, 0);
      chk("midrst_miso", bus.MISO, 0);
      wait_clk(3);
      rst = 1'b1;
      cs_rise();
      sb_q.push_back(8'hC3);
      cs_fall(1'b1, 1'b1, 8'h96);
      shift_bits(1'b1, 1'b1, 16'h00C3, 8);
      cs_rise();
      wait_drain();
      chk("post_rst_master_rx", miso_bits[W-1:0], 8'h96);
      chk("post_rst_count", rx_count, count0 + 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
